// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller.
//   ch_state_t   : per-channel state (IDLE / REQ / SERVICE)
//   CFG_ENABLE   : cfg_addr value selecting the enable register
//   CFG_FIQSEL   : cfg_addr value selecting the FIQ-select register
//   DEF_*_BASE   : default vector bases
//   vec_addr()   : base + 4*id with id zero-extended, 32-bit arithmetic
package int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } ch_state_t;

    localparam logic CFG_ENABLE = 1'b0;
    localparam logic CFG_FIQSEL = 1'b1;

    localparam logic [31:0] DEF_IRQ_BASE = 32'h0000_0020;
    localparam logic [31:0] DEF_FIQ_BASE = 32'h0000_0040;

    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [3:0] id);
        return base + {26'd0, id, 2'b00};
    endfunction

endpackage

// File: rtl/int_channel.sv
// One interrupt channel (used once for FIQ, once for IRQ).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   eligible   : sources this channel may dispatch (pending & enable & routing)
//   ack, eoi   : acknowledge / end-of-interrupt, already qualified for this channel
//   state      : current FSM state (also the debug view of the channel)
//   id         : source latched when the channel entered REQ
//   take       : high in the cycle an ack is accepted; top clears pending[id]
//   nxt_req    : channel will be in REQ after this edge
//   nxt_id     : id the channel will hold after this edge
// Handshake: the line is asserted while state is REQ; an ack is accepted only
// in REQ and an eoi only in SERVICE, any other ack/eoi is ignored.
module int_channel
    import int_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] eligible,
    input  logic             ack,
    input  logic             eoi,
    output ch_state_t        state,
    output logic [3:0]       id,
    output logic             take,
    output logic             nxt_req,
    output logic [3:0]       nxt_id
);

    ch_state_t  state_nxt;
    logic       found;
    logic [3:0] win;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        found = 1'b0;
        win   = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                win   = 4'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        nxt_id    = id;
        take      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt = ST_REQ;
                    nxt_id    = win;
                end
            end
            ST_REQ: begin
                // Committed: only an ack moves it on, eligibility is not rechecked.
                if (ack) begin
                    take      = 1'b1;
                    state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        nxt_req = (state_nxt == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            id    <= 4'd0;
        end else begin
            state <= state_nxt;
            id    <= nxt_id;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects source requests, applies enable and
// FIQ/IRQ routing, and drives EX_irq / EX_fiq / INT_Vector to the CPU through
// a request -> ack -> eoi handshake per channel.
// Ports:
//   clk, Rst              : clock, synchronous active-high reset
//   src_req               : source request levels (rising edge posts)
//   cfg_we/addr/wdata     : config write (addr 0 enable, 1 FIQ select)
//   int_ack, int_eoi      : CPU handshake pulses, int_ack_fiq selects channel
//   EX_irq, EX_fiq        : request lines to the CPU
//   INT_Vector            : handler address of the active request
//   pending               : latched, not yet acknowledged sources
//   irq_id, fiq_id        : source held by each channel
//   irq_busy, fiq_busy    : channel not idle
module int_ctrl
    import int_pkg::*;
#(
    parameter int          N_SRC    = 4,
    parameter logic [31:0] IRQ_BASE = DEF_IRQ_BASE,
    parameter logic [31:0] FIQ_BASE = DEF_FIQ_BASE
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] src_req,
    input  logic             cfg_we,
    input  logic             cfg_addr,
    input  logic [N_SRC-1:0] cfg_wdata,
    input  logic             int_ack,
    input  logic             int_ack_fiq,
    input  logic             int_eoi,
    output logic             EX_irq,
    output logic             EX_fiq,
    output logic [31:0]      INT_Vector,
    output logic [N_SRC-1:0] pending,
    output logic [3:0]       irq_id,
    output logic [3:0]       fiq_id,
    output logic             irq_busy,
    output logic             fiq_busy
);

    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] fiqsel;
    logic [N_SRC-1:0] pend_set;
    logic [N_SRC-1:0] pend_clr;

    ch_state_t  irq_state, fiq_state;
    logic       irq_take, fiq_take;
    logic       irq_nxt_req, fiq_nxt_req;
    logic [3:0] irq_nxt_id, fiq_nxt_id;

    int_channel #(.N_SRC(N_SRC)) u_irq (
        .clk      (clk),
        .rst      (Rst),
        .eligible (pending & enable & ~fiqsel),
        .ack      (int_ack & ~int_ack_fiq),
        .eoi      (int_eoi & ~int_ack_fiq),
        .state    (irq_state),
        .id       (irq_id),
        .take     (irq_take),
        .nxt_req  (irq_nxt_req),
        .nxt_id   (irq_nxt_id)
    );

    int_channel #(.N_SRC(N_SRC)) u_fiq (
        .clk      (clk),
        .rst      (Rst),
        .eligible (pending & enable & fiqsel),
        .ack      (int_ack & int_ack_fiq),
        .eoi      (int_eoi & int_ack_fiq),
        .state    (fiq_state),
        .id       (fiq_id),
        .take     (fiq_take),
        .nxt_req  (fiq_nxt_req),
        .nxt_id   (fiq_nxt_id)
    );

    // Lines and busy flags are pure decodes of the state registers.
    assign EX_irq   = (irq_state == ST_REQ);
    assign EX_fiq   = (fiq_state == ST_REQ);
    assign irq_busy = (irq_state != ST_IDLE);
    assign fiq_busy = (fiq_state != ST_IDLE);

    assign pend_set = src_req & ~src_prev;

    always_comb begin
        pend_clr = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if ((irq_take && irq_id == 4'(k)) || (fiq_take && fiq_id == 4'(k))) begin
                pend_clr[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            src_prev   <= '0;
            pending    <= '0;
            enable     <= '0;
            fiqsel     <= '0;
            INT_Vector <= 32'd0;
        end else begin
            src_prev <= src_req;
            // A new edge wins over a clear of the same bit.
            pending  <= (pending & ~pend_clr) | pend_set;
            if (cfg_we) begin
                if (cfg_addr == CFG_ENABLE) enable <= cfg_wdata;
                else                        fiqsel <= cfg_wdata;
            end
            // Vector follows the channel states this edge produces so it is
            // valid together with the line; FIQ has precedence on the shared bus.
            if (fiq_nxt_req)      INT_Vector <= vec_addr(FIQ_BASE, fiq_nxt_id);
            else if (irq_nxt_req) INT_Vector <= vec_addr(IRQ_BASE, irq_nxt_id);
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed test-plan sequence followed by randomized
// traffic, every cycle compared against a behavioural model.
module tb_int_ctrl;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          Rst;
    logic [N-1:0]  src_req;
    logic          cfg_we;
    logic          cfg_addr;
    logic [N-1:0]  cfg_wdata;
    logic          int_ack;
    logic          int_ack_fiq;
    logic          int_eoi;
    logic          EX_irq;
    logic          EX_fiq;
    logic [31:0]   INT_Vector;
    logic [N-1:0]  pending;
    logic [3:0]    irq_id;
    logic [3:0]    fiq_id;
    logic          irq_busy;
    logic          fiq_busy;

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int_ctrl #(.N_SRC(N)) dut (
        .clk         (clk),
        .Rst         (Rst),
        .src_req     (src_req),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .int_ack     (int_ack),
        .int_ack_fiq (int_ack_fiq),
        .int_eoi     (int_eoi),
        .EX_irq      (EX_irq),
        .EX_fiq      (EX_fiq),
        .INT_Vector  (INT_Vector),
        .pending     (pending),
        .irq_id      (irq_id),
        .fiq_id      (fiq_id),
        .irq_busy    (irq_busy),
        .fiq_busy    (fiq_busy)
    );

    // ---------------- reference model ----------------
    // Channel phase: 0 idle, 1 requesting, 2 in service. Index 0 = IRQ, 1 = FIQ.
    logic [N-1:0] m_pend, m_en, m_sel, m_prev;
    int           m_ph[2];
    int           m_id[2];
    logic [31:0]  m_vec;

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_sel = '0; m_prev = '0;
        m_ph[0] = 0; m_ph[1] = 0; m_id[0] = 0; m_id[1] = 0;
        m_vec = 32'd0;
    endtask

    // Applies one clock edge worth of the rules to the model, using the
    // inputs currently driven.
    task automatic model_step();
        logic [N-1:0] set_b, clr_b;
        int ph_n[2];
        int id_n[2];
        logic is_fiq;
        if (Rst) begin
            model_reset();
            return;
        end
        set_b = src_req & ~m_prev;
        clr_b = '0;
        for (int c = 0; c < 2; c++) begin
            is_fiq  = (c == 1);
            ph_n[c] = m_ph[c];
            id_n[c] = m_id[c];
            if (m_ph[c] == 1) begin
                if (int_ack && int_ack_fiq == is_fiq) begin
                    clr_b   = clr_b | N'(1 << m_id[c]);
                    ph_n[c] = 2;
                end
            end else if (m_ph[c] == 2) begin
                if (int_eoi && int_ack_fiq == is_fiq) ph_n[c] = 0;
            end else begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (m_pend[k] && m_en[k] && (m_sel[k] == is_fiq)) begin
                        ph_n[c] = 1;
                        id_n[c] = k;
                    end
                end
            end
        end
        m_pend = (m_pend & ~clr_b) | set_b;
        if (cfg_we) begin
            if (cfg_addr) m_sel = cfg_wdata;
            else          m_en  = cfg_wdata;
        end
        m_prev = src_req;
        m_ph = ph_n;
        m_id = id_n;
        if (m_ph[1] == 1)      m_vec = 32'h40 + 32'(4 * m_id[1]);
        else if (m_ph[0] == 1) m_vec = 32'h20 + 32'(4 * m_id[0]);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        logic [31:0] e;
        exp_q.push_back(32'(m_ph[0] == 1));
        exp_q.push_back(32'(m_ph[1] == 1));
        exp_q.push_back(m_vec);
        exp_q.push_back(32'(m_pend));
        exp_q.push_back(32'(m_id[0]));
        exp_q.push_back(32'(m_id[1]));
        exp_q.push_back(32'(m_ph[0] != 0));
        exp_q.push_back(32'(m_ph[1] != 0));
        e = exp_q.pop_front(); check("m_EX_irq",   32'(EX_irq),   e);
        e = exp_q.pop_front(); check("m_EX_fiq",   32'(EX_fiq),   e);
        e = exp_q.pop_front(); check("m_vector",   INT_Vector,    e);
        e = exp_q.pop_front(); check("m_pending",  32'(pending),  e);
        e = exp_q.pop_front(); check("m_irq_id",   32'(irq_id),   e);
        e = exp_q.pop_front(); check("m_fiq_id",   32'(fiq_id),   e);
        e = exp_q.pop_front(); check("m_irq_busy", 32'(irq_busy), e);
        e = exp_q.pop_front(); check("m_fiq_busy", 32'(fiq_busy), e);
    endtask

    // ---------------- driver tasks ----------------
    // One edge: model follows, DUT sampled 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cfg_write(input logic addr, input logic [N-1:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_ack(input logic fiq);
        int_ack = 1'b1; int_ack_fiq = fiq;
        tick();
        int_ack = 1'b0; int_ack_fiq = 1'b0;
    endtask

    task automatic pulse_eoi(input logic fiq);
        int_eoi = 1'b1; int_ack_fiq = fiq;
        tick();
        int_eoi = 1'b0; int_ack_fiq = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        Rst = 1'b1; src_req = '0; cfg_we = 1'b0; cfg_addr = 1'b0; cfg_wdata = '0;
        int_ack = 1'b0; int_ack_fiq = 1'b0; int_eoi = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check("rst_vector",  INT_Vector, 32'h0);
        check("rst_lines",   32'({EX_irq, EX_fiq, irq_busy, fiq_busy}), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        Rst = 1'b0;

        // single IRQ source, full handshake
        cfg_write(1'b0, 4'b0100);
        cfg_write(1'b1, 4'b0000);
        src_req = 4'b0100;
        tick();
        check("t1_pending_t1", 32'(pending), 32'h4);
        check("t1_irq_early",  32'(EX_irq),  32'h0);
        tick();
        check("t1_irq_high",   32'(EX_irq),  32'h1);
        check("t1_vector",     INT_Vector,   32'h28);
        src_req = '0;
        pulse_ack(1'b0);
        check("t1_irq_drop",   32'(EX_irq),  32'h0);
        check("t1_pend_clr",   32'(pending), 32'h0);
        pulse_eoi(1'b0);
        check("t1_idle",       32'(irq_busy), 32'h0);

        // FIQ and IRQ at once, FIQ owns the vector first
        cfg_write(1'b0, 4'b1111);
        cfg_write(1'b1, 4'b0010);
        src_req = 4'b1010;
        tick();
        tick();
        check("t2_both",       32'({EX_fiq, EX_irq}), 32'h3);
        check("t2_vec_fiq",    INT_Vector, 32'h44);
        src_req = '0;
        pulse_ack(1'b1);
        check("t2_vec_irq",    INT_Vector, 32'h2C);
        check("t2_fiq_drop",   32'(EX_fiq), 32'h0);
        pulse_eoi(1'b1);
        pulse_ack(1'b0);
        pulse_eoi(1'b0);

        // priority and re-request after eoi
        cfg_write(1'b1, 4'b0000);
        src_req = 4'b0101;
        tick();
        tick();
        check("t3_first_id",   32'(irq_id), 32'h0);
        check("t3_first_vec",  INT_Vector,  32'h20);
        src_req = '0;
        pulse_ack(1'b0);
        pulse_eoi(1'b0);
        check("t3_gap",        32'(EX_irq), 32'h0);
        tick();
        check("t3_rereq",      32'(EX_irq), 32'h1);
        check("t3_rereq_vec",  INT_Vector,  32'h28);
        pulse_ack(1'b0);
        pulse_eoi(1'b0);

        // disabled source latches but waits for enable
        cfg_write(1'b0, 4'b0000);
        src_req = 4'b1000;
        tick();
        src_req = '0;
        tick();
        check("t4_pend_dis",   32'(pending), 32'h8);
        check("t4_no_irq",     32'(EX_irq),  32'h0);
        cfg_write(1'b0, 4'b1000);
        check("t4_wait",       32'(EX_irq),  32'h0);
        tick();
        check("t4_irq_en",     32'(EX_irq),  32'h1);

        // FIQ ack while FIQ idle is ignored
        pulse_ack(1'b1);
        check("t5_irq_kept",   32'(EX_irq),   32'h1);
        check("t5_fiq_idle",   32'(fiq_busy), 32'h0);
        check("t5_pend_kept",  32'(pending),  32'h8);

        // reset during service
        pulse_ack(1'b0);
        src_req = 4'b1000;
        tick();
        check("t6_pend_set",   32'(pending),  32'h8);
        check("t6_in_service", 32'(irq_busy), 32'h1);
        src_req = '0;
        Rst = 1'b1;
        tick();
        check("t6_rst_all",    32'({EX_irq, EX_fiq, irq_busy, fiq_busy}), 32'h0);
        check("t6_rst_pend",   32'(pending),  32'h0);
        check("t6_rst_vec",    INT_Vector,    32'h0);
        Rst = 1'b0;

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            src_req     = N'($urandom_range(0, 15));
            cfg_we      = ($urandom_range(0, 7) == 0);
            cfg_addr    = 1'($urandom_range(0, 1));
            cfg_wdata   = N'($urandom);
            int_ack     = ($urandom_range(0, 2) == 0);
            int_eoi     = ($urandom_range(0, 3) == 0);
            int_ack_fiq = 1'($urandom_range(0, 1));
            Rst         = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
